// File: rtl/serial_add_ctrl_if.sv
// Handshake/data bundle for the bit-serial adder sequencer.
// master: start, a, b, cin out; busy, done, sum, cout, overflow in.
// slave : the sequencer side, directions mirrored.
interface serial_add_ctrl_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout, overflow
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout, overflow
   );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial N-bit adder: one 1-bit full adder reused over WIDTH cycles.
// Ports: clk, reset (async, active-high); bus = start/a/b/cin in,
// busy/done/sum/cout/overflow out (serial_add_ctrl_if.slave).
module FullAdder (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);
   assign s_o = a_i ^ b_i ^ c_i;
   assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input logic           clk,
   input logic           reset,
   serial_add_ctrl_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic             fa_s;
   logic             fa_c;
   logic [WIDTH-1:0] sum_shift;

   FullAdder u_fa (
      .a_i (a_sh_q[0]),
      .b_i (b_sh_q[0]),
      .c_i (carry_q),
      .s_o (fa_s),
      .c_o (fa_c)
   );

   // New bit enters at the MSB; after WIDTH shifts bit i is result bit i.
   assign sum_shift = WIDTH'({fa_s, sum_sh_q} >> 1);

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      sum_sh_d = sum_sh_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      sum_d    = sum_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_sh_d   = bus.a;
               b_sh_d   = bus.b;
               carry_d  = bus.cin;
               sum_sh_d = '0;
               cnt_d    = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            carry_d  = fa_c;
            sum_sh_d = sum_shift;
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               sum_d   = sum_shift;
               cout_d  = fa_c;
               // carry out of MSB xor carry into MSB
               ovf_d   = fa_c ^ carry_q;
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         sum_sh_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         sum_sh_q <= sum_sh_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         sum_q    <= sum_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.busy     = (state_q == RUN);
   assign bus.done     = (state_q == DONE);
   assign bus.sum      = sum_q;
   assign bus.cout     = cout_q;
   assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=1.
// Expected results are queued at start and popped on done.
module tb_serial_add_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   serial_add_ctrl_if #(.WIDTH(8)) if8 ();
   serial_add_ctrl_if #(.WIDTH(1)) if1 ();

   serial_add_ctrl #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .reset (reset),
      .bus   (if8)
   );

   serial_add_ctrl #(.WIDTH(1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (if1)
   );

   typedef struct packed {
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } exp8_t;

   typedef struct packed {
      logic sum;
      logic cout;
      logic ovf;
   } exp1_t;

   exp8_t sb8[$];
   exp1_t sb1[$];

   function automatic exp8_t model8(
      input logic [7:0] a, input logic [7:0] b, input logic c);
      logic [8:0] r;
      exp8_t e;
      r = {1'b0, a} + {1'b0, b} + {8'd0, c};
      e.sum  = r[7:0];
      e.cout = r[8];
      e.ovf  = (a[7] == b[7]) && (r[7] != a[7]);
      return e;
   endfunction

   function automatic exp1_t model1(
      input logic a, input logic b, input logic c);
      exp1_t e;
      e.sum  = a ^ b ^ c;
      e.cout = (a & b) | (c & (a ^ b));
      e.ovf  = (a == b) && (e.sum != a);
      return e;
   endfunction

   task automatic start8(
      input logic [7:0] a, input logic [7:0] b, input logic c);
      @(negedge clk);
      if8.start = 1'b1;
      if8.a = a;
      if8.b = b;
      if8.cin = c;
      sb8.push_back(model8(a, b, c));
      @(posedge clk);
      #1 if8.start = 1'b0;
   endtask

   task automatic start1(
      input logic a, input logic b, input logic c);
      @(negedge clk);
      if1.start = 1'b1;
      if1.a = a;
      if1.b = b;
      if1.cin = c;
      sb1.push_back(model1(a, b, c));
      @(posedge clk);
      #1 if1.start = 1'b0;
   endtask

   // k = index of the negedge (0 = first after the start edge) with done
   task automatic wait_done8(output int k, output bit seen);
      seen = 0;
      k = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (if8.done) begin
            k = i;
            seen = 1;
            break;
         end
      end
   endtask

   task automatic wait_done1(output int k, output bit seen);
      seen = 0;
      k = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (if1.done) begin
            k = i;
            seen = 1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      logic [11:0] o8;
      logic [4:0]  o1;
      @(negedge clk);
      o8 = {if8.busy, if8.done, if8.cout, if8.overflow, if8.sum};
      o1 = {if1.busy, if1.done, if1.cout, if1.overflow, if1.sum};
      checks++;
      if (o8 !== 12'h000) begin
         errors++;
         $display("FAIL reset8: got %h want 000", o8);
      end
      checks++;
      if (o1 !== 5'h00) begin
         errors++;
         $display("FAIL reset1: got %h want 00", o1);
      end
   endtask

   task automatic test_latency;
      int    bad_busy;
      int    done_k;
      int    ndone;
      exp8_t e;
      bad_busy = 0;
      done_k = -1;
      ndone = 0;
      start8(8'h5A, 8'h33, 1'b0);
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (if8.busy !== (k < 8)) bad_busy++;
         if (if8.done === 1'b1) begin
            ndone++;
            if (done_k < 0) done_k = k;
            e = sb8.pop_front();
            checks++;
            if ({if8.sum, if8.cout, if8.overflow} !== e) begin
               errors++;
               $display("FAIL first_op: got %h/%b/%b want %h/%b/%b",
                  if8.sum, if8.cout, if8.overflow,
                  e.sum, e.cout, e.ovf);
            end
         end
      end
      checks++;
      if (bad_busy != 0) begin
         errors++;
         $display("FAIL busy_window: got %0d bad cycles want 0",
            bad_busy);
      end
      // edges counted inclusively from the start edge
      checks++;
      if (done_k + 1 != 9 || ndone != 1) begin
         errors++;
         $display("FAIL done_latency: got %0d edges, %0d pulses want 9, 1",
            done_k + 1, ndone);
      end
      checks++;
      if (if8.sum !== 8'h8D) begin
         errors++;
         $display("FAIL sum_hold: got %h want 8d", if8.sum);
      end
   endtask

   task automatic test_vectors;
      logic [16:0] tbl [4];
      int    k;
      bit    seen;
      exp8_t e;
      tbl[0] = {8'hFF, 8'h01, 1'b0};
      tbl[1] = {8'hFF, 8'h00, 1'b1};
      tbl[2] = {8'h80, 8'h80, 1'b0};
      tbl[3] = {8'h7F, 8'h00, 1'b1};
      for (int i = 0; i < 4; i++) begin
         start8(tbl[i][16:9], tbl[i][8:1], tbl[i][0]);
         wait_done8(k, seen);
         e = sb8.pop_front();
         checks++;
         if (!seen) begin
            errors++;
            $display("FAIL vec%0d_timeout: got no done want done", i);
         end else if ({if8.sum, if8.cout, if8.overflow} !== e) begin
            errors++;
            $display("FAIL vec%0d: got %h/%b/%b want %h/%b/%b", i,
               if8.sum, if8.cout, if8.overflow,
               e.sum, e.cout, e.ovf);
         end
      end
   endtask

   task automatic test_ignore_start;
      int    ndone;
      int    busy_after;
      exp8_t e;
      ndone = 0;
      busy_after = 0;
      start8(8'h12, 8'h34, 1'b0);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (k == 2) begin
            if8.start = 1'b1;
            if8.a = 8'hFF;
            if8.b = 8'hFF;
         end else if (k == 3) begin
            if8.start = 1'b0;
            if8.a = 8'h00;
            if8.b = 8'h77;
            if8.cin = 1'b1;
         end
         if (ndone > 0 && if8.busy === 1'b1) busy_after++;
         if (if8.done === 1'b1) begin
            ndone++;
            if (sb8.size() > 0) begin
               e = sb8.pop_front();
               checks++;
               if ({if8.sum, if8.cout, if8.overflow} !== e) begin
                  errors++;
                  $display("FAIL ignore_result: got %h/%b want %h/%b",
                     if8.sum, if8.cout, e.sum, e.cout);
               end
            end
         end
      end
      checks++;
      if (ndone != 1 || busy_after != 0) begin
         errors++;
         $display("FAIL ignore_start: got %0d dones, %0d busy want 1, 0",
            ndone, busy_after);
      end
      if8.cin = 1'b0;
   endtask

   task automatic test_async_reset;
      logic [11:0] o8;
      int    ndone;
      int    k;
      bit    seen;
      exp8_t e;
      ndone = 0;
      start8(8'hAA, 8'h55, 1'b0);
      for (int i = 0; i < 4; i++) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      o8 = {if8.busy, if8.done, if8.cout, if8.overflow, if8.sum};
      checks++;
      if (o8 !== 12'h000) begin
         errors++;
         $display("FAIL async_reset: got %h want 000", o8);
      end
      sb8.delete();
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (if8.done === 1'b1 || if8.busy === 1'b1) ndone++;
      end
      checks++;
      if (ndone != 0) begin
         errors++;
         $display("FAIL no_done_after_reset: got %0d want 0", ndone);
      end
      start8(8'h01, 8'h01, 1'b0);
      wait_done8(k, seen);
      e = sb8.pop_front();
      checks++;
      if (!seen || if8.sum !== 8'h02 || {if8.sum, if8.cout,
          if8.overflow} !== e) begin
         errors++;
         $display("FAIL post_reset_op: got %h seen=%0d want 02",
            if8.sum, seen);
      end
   endtask

   task automatic test_start_held;
      int    idx [3];
      int    n;
      exp8_t e;
      n = 0;
      @(negedge clk);
      if8.start = 1'b1;
      if8.a = 8'h0F;
      if8.b = 8'h01;
      if8.cin = 1'b0;
      for (int i = 0; i < 3; i++) sb8.push_back(model8(8'h0F, 8'h01, 1'b0));
      for (int i = 0; i < 45; i++) begin
         @(negedge clk);
         if (if8.done === 1'b1) begin
            idx[n] = i;
            n++;
            e = sb8.pop_front();
            checks++;
            if ({if8.sum, if8.cout, if8.overflow} !== e) begin
               errors++;
               $display("FAIL held_result%0d: got %h want %h", n,
                  if8.sum, e.sum);
            end
            if (n == 3) begin
               if8.start = 1'b0;
               break;
            end
         end
      end
      checks++;
      if (n != 3) begin
         errors++;
         $display("FAIL held_count: got %0d want 3", n);
      end else if (idx[1] - idx[0] != 10 || idx[2] - idx[1] != 10) begin
         errors++;
         $display("FAIL held_spacing: got %0d,%0d want 10,10",
            idx[1] - idx[0], idx[2] - idx[1]);
      end
      if8.start = 1'b0;
      sb8.delete();
   endtask

   task automatic test_random8;
      int    k;
      bit    seen;
      exp8_t e;
      logic [7:0] a;
      logic [7:0] b;
      logic c;
      for (int i = 0; i < 1000; i++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         c = 1'($urandom);
         start8(a, b, c);
         wait_done8(k, seen);
         e = sb8.pop_front();
         checks++;
         if (!seen || k != 8) begin
            errors++;
            $display("FAIL rand8_timing%0d: got k=%0d want 8", i, k);
         end else if ({if8.sum, if8.cout, if8.overflow} !== e) begin
            errors++;
            $display("FAIL rand8_%0d: %h+%h+%b got %h/%b/%b want %h/%b/%b",
               i, a, b, c, if8.sum, if8.cout, if8.overflow,
               e.sum, e.cout, e.ovf);
         end
      end
   endtask

   task automatic test_random1;
      int    k;
      bit    seen;
      exp1_t e;
      logic a;
      logic b;
      logic c;
      for (int i = 0; i < 1000; i++) begin
         a = 1'($urandom);
         b = 1'($urandom);
         c = 1'($urandom);
         start1(a, b, c);
         wait_done1(k, seen);
         e = sb1.pop_front();
         checks++;
         if (!seen || k != 1) begin
            errors++;
            $display("FAIL rand1_timing%0d: got k=%0d want 1", i, k);
         end else if ({if1.sum, if1.cout, if1.overflow} !== e) begin
            errors++;
            $display("FAIL rand1_%0d: %b+%b+%b got %b%b%b want %b%b%b",
               i, a, b, c, if1.sum, if1.cout, if1.overflow,
               e.sum, e.cout, e.ovf);
         end
      end
   endtask

   initial begin
      if8.start = 1'b0;
      if8.a = '0;
      if8.b = '0;
      if8.cin = 1'b0;
      if1.start = 1'b0;
      if1.a = '0;
      if1.b = '0;
      if1.cin = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      reset = 1'b0;
      test_latency();
      test_vectors();
      test_ignore_start();
      test_async_reset();
      test_start_held();
      test_random8();
      test_random1();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
